// File: rtl/disp_feed_sched.sv
// Display feed sequencer: double-dabble BCD conversion, blanking/error marking (DISP_ERR_BLINK_EN adds error blink).
// Latency: outputs and upd_done appear WIDTH+1 edges after the accepting edge.
// Backpressure: in_ready only in IDLE; no queuing, in_valid ignored while busy.
module disp_feed_sched #(
  parameter int WIDTH     = 14,
  parameter int MAXVAL    = 9999,
  parameter int BLINK_DIV = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [3:0]       in_dp,
  input  logic             in_err,
  input  logic             tick100,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dec_point,
  output logic [3:0]       blank,
  output logic [3:0]       error,
  output logic             upd_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAXVAL);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] bin_sr;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [3:0]       dp_l;
  logic             err_l;
  logic [3:0]       blank_r;
  logic [3:0]       blank_nxt;
  logic             lead;

  assign in_ready = (state == IDLE) && !reset;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit blanks only while every digit to its left is zero and no decimal point sits at or left of it.
  always_comb begin
    blank_nxt = 4'b0000;
    lead      = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      lead         = lead && (bcd[4*i +: 4] == 4'd0) && !dp_l[i];
      blank_nxt[i] = lead;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bin_sr    <= '0;
      bcd       <= '0;
      dp_l      <= 4'b0000;
      err_l     <= 1'b0;
      dig0      <= 4'd0;
      dig1      <= 4'd0;
      dig2      <= 4'd0;
      dig3      <= 4'd0;
      dec_point <= 4'b0000;
      blank_r   <= 4'b1110;
      error     <= 4'b0000;
      upd_done  <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr <= in_value;
            bcd    <= '0;
            cnt    <= '0;
            dp_l   <= in_dp;
            err_l  <= in_err || (in_value > MAX_W);
            state  <= CONV;
          end
        end
        CONV: begin
          {bcd, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
          cnt           <= cnt + 1'b1;
          if (cnt == LAST) state <= COMMIT;
        end
        COMMIT: begin
          upd_done <= 1'b1;
          state    <= IDLE;
          if (err_l) begin
            {dig3, dig2, dig1, dig0} <= 16'h0000;
            dec_point <= 4'b0000;
            blank_r   <= 4'b0000;
            error     <= 4'b1111;
          end else begin
            {dig3, dig2, dig1, dig0} <= bcd;
            dec_point <= dp_l;
            blank_r   <= blank_nxt;
            error     <= 4'b0000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISP_ERR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  always_ff @(posedge clk) begin
    if (reset || state == COMMIT) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (error == 4'b1111 && tick100) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= !blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blank = blank_r | {4{blink_ph}};
`else
  logic unused_tick;
  assign unused_tick = tick100 ^ (BLINK_DIV > 0);
  assign blank       = blank_r;
`endif
endmodule

// File: tb/tb_disp_feed_sched.sv
// Directed bench for disp_feed_sched: reset state, conversion, blanking, error path, abort and back-to-back accept.
module tb_disp_feed_sched;
  localparam int WIDTH = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic [3:0]       in_dp;
  logic             in_err;
  logic             tick100;
  logic [3:0]       dig0, dig1, dig2, dig3;
  logic [3:0]       dec_point, blank, error;
  logic             upd_done;

  int n_vec  = 0;
  int n_fail = 0;
  int lat;
  int seen;

  disp_feed_sched dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_dp(in_dp), .in_err(in_err), .tick100(tick100),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dec_point(dec_point), .blank(blank), .error(error), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] digs, input logic [3:0] dp,
                          input logic [3:0] bl, input logic [3:0] er);
    chk({tag, "_digits"}, {16'h0, dig3, dig2, dig1, dig0}, {16'h0, digs});
    chk({tag, "_dp"}, {28'h0, dec_point}, {28'h0, dp});
    chk({tag, "_blank"}, {28'h0, blank}, {28'h0, bl});
    chk({tag, "_error"}, {28'h0, error}, {28'h0, er});
  endtask

  // Called at posedge+1 with in_ready high; returns at posedge+1 of the upd_done cycle.
  task automatic xfer(input logic [WIDTH-1:0] v, input logic [3:0] dp, input logic e,
                      input logic hold, output int l);
    in_value = v;
    in_dp    = dp;
    in_err   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    l = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      l++;
      if (upd_done) break;
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    in_dp    = 4'b0000;
    in_err   = 1'b0;
    tick100  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_upd", {31'h0, upd_done}, 32'd0);
    chk_disp("rst", 16'h0000, 4'b0000, 4'b1110, 4'b0000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'h0, in_ready}, 32'd1);

    xfer(14'd1234, 4'b0000, 1'b0, 1'b0, lat);
    chk("lat_1234", lat, WIDTH + 1);
    chk("ready_on_upd", {31'h0, in_ready}, 32'd1);
    chk_disp("v1234", 16'h1234, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    chk("upd_pulse", {31'h0, upd_done}, 32'd0);

    xfer(14'd7, 4'b0000, 1'b0, 1'b0, lat);
    chk_disp("v7", 16'h0007, 4'b0000, 4'b1110, 4'b0000);
    xfer(14'd0, 4'b0000, 1'b0, 1'b0, lat);
    chk_disp("v0", 16'h0000, 4'b0000, 4'b1110, 4'b0000);
    xfer(14'd5, 4'b0100, 1'b0, 1'b0, lat);
    chk_disp("v5dp", 16'h0005, 4'b0100, 4'b1000, 4'b0000);
    xfer(14'd100, 4'b0000, 1'b0, 1'b0, lat);
    chk_disp("v100", 16'h0100, 4'b0000, 4'b1000, 4'b0000);
    xfer(14'd9999, 4'b0000, 1'b0, 1'b0, lat);
    chk_disp("v9999", 16'h9999, 4'b0000, 4'b0000, 4'b0000);

    xfer(14'd10000, 4'b0010, 1'b0, 1'b0, lat);
    chk("lat_ovf", lat, WIDTH + 1);
    chk_disp("ovf", 16'h0000, 4'b0000, 4'b0000, 4'b1111);
    xfer(14'd42, 4'b0000, 1'b1, 1'b0, lat);
    chk_disp("in_err", 16'h0000, 4'b0000, 4'b0000, 4'b1111);

    // Abort a conversion of 9999 with reset in its fifth CONV cycle.
    in_value = 14'd9999;
    in_dp    = 4'b0000;
    in_err   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("conv_busy", {31'h0, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_in_rst", {31'h0, in_ready}, 32'd0);
    chk_disp("abort", 16'h0000, 4'b0000, 4'b1110, 4'b0000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready_after", {31'h0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (upd_done) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("abort_no_upd", seen, 0);
    chk_disp("abort_hold", 16'h0000, 4'b0000, 4'b1110, 4'b0000);

    // Hold in_valid high: 12 commits, then 34 is taken on the upd_done cycle.
    xfer(14'd12, 4'b0000, 1'b0, 1'b1, lat);
    chk("lat_12", lat, WIDTH + 1);
    chk_disp("v12", 16'h0012, 4'b0000, 4'b1100, 4'b0000);
    xfer(14'd34, 4'b0000, 1'b0, 1'b0, lat);
    chk("lat_34", lat, WIDTH + 1);
    chk_disp("v34", 16'h0034, 4'b0000, 4'b1100, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
